flipdot_frame_rx: RTL

serial receiver and decoder for flip-dot panel frames, i.e. the panel-side end of the 8N1 UART frame stream the ball-detector path transmits. It decodes one 28x7 panel image into column writes.

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1302, meaning iCLK cycles per UART bit.
REQ-002 The block SHALL have parameter PANEL_ADDR, default 8'h00, meaning the panel address this instance accepts.
REQ-003 Port iCLK  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 Port iRST_N  input  1  asynchronous, active-low reset.
REQ-005 Port iRXD  input  1  asynchronous serial line; idle high.
REQ-006 Port oCOL_WE  output  1  one-cycle column write strobe.
REQ-007 Port oCOL_ADDR  output  5  column index, 0..27.
REQ-008 Port oCOL_DATA  output  7  column dots; bit0 is the top row.
REQ-009 Port oFRAME_DONE  output  1  one-cycle pulse on a valid end byte.
REQ-010 Port oREFRESH  output  1  level, valid while oFRAME_DONE=1; 1 = command 0x83, 0 = command 0x84.
REQ-011 Port oFRAME_ERR  output  1  one-cycle error pulse.
REQ-012 Port oBUSY  output  1  high while the parser is outside HUNT.

Function -- UART receive
REQ-013 iRXD SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Start-bit detection and validation:
- A synchronized high-to-low transition SHALL start a byte.
- The line SHALL be re-sampled after CLKS_PER_BIT/2 cycles.
- If the line is high at that sample, the start is a glitch: return to idle, no error.
REQ-015 Data bits:
- 8 data bits SHALL be sampled LSB first.
- Samples are spaced CLKS_PER_BIT cycles apart, starting from the start-bit mid-point.
REQ-016 Stop bit:
- It SHALL be sampled one bit-time after data bit 7.
- High: the byte is valid and is presented to the parser as a one-cycle strobe.
- Low: framing error. Discard the byte, pulse oFRAME_ERR, force the parser to HUNT, and wait for the line to be high before re-arming.
REQ-017 The bit counter and the baud counter SHALL NOT wrap mid-byte. A new start bit SHALL be accepted starting the cycle after the stop-bit sample.

Function -- frame parser

---
 rtl/flipdot_frame_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/flipdot_frame_rx.sv
// Purpose: 8N1 UART receiver and frame parser that turns one 28x7 flip-dot image into column writes.
// Latency: a column write, done or error pulse appears one cycle after the stop-bit sample of its byte.
// Backpressure: none; the serial line cannot be stalled, so every output is a one-cycle strobe.
module flipdot_frame_rx #(
   parameter int          CLKS_PER_BIT = 1302,
   parameter logic [7:0]  PANEL_ADDR   = 8'h00
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iRXD,
   output logic       oCOL_WE,
   output logic [4:0] oCOL_ADDR,
   output logic [6:0] oCOL_DATA,
   output logic       oFRAME_DONE,
   output logic       oREFRESH,
   output logic       oFRAME_ERR,
   output logic       oBUSY
);

   localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT_HIGH} ustate_t;
   typedef enum logic [2:0] {P_HUNT, P_CMD, P_ADDR, P_DATA, P_END} pstate_t;

   ustate_t       ustate;
   pstate_t       pstate;
   logic          rxd_s1, rxd_s2, rxd_d;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_dat;
   logic          stop_tick, byte_vld, byte_ferr;
   logic          match, cmd_refresh;
   logic [4:0]    col_cnt;

   // Synchronizer resets to the idle level so reset release never looks like a start edge.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
         rxd_d  <= 1'b1;
      end else begin
         rxd_s1 <= iRXD;
         rxd_s2 <= rxd_s1;
         rxd_d  <= rxd_s2;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         ustate    <= U_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_dat <= '0;
      end else begin
         case (ustate)
            U_IDLE: begin
               baud_cnt <= '0;
               if (rxd_d && !rxd_s2) ustate <= U_START;
            end
            U_START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  ustate   <= rxd_s2 ? U_IDLE : U_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            U_DATA: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt  <= '0;
                  shift_dat <= {rxd_s2, shift_dat[7:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) ustate <= U_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            U_STOP: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  ustate   <= rxd_s2 ? U_IDLE : U_WAIT_HIGH;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            U_WAIT_HIGH: begin
               if (rxd_s2) ustate <= U_IDLE;
            end
            default: ustate <= U_IDLE;
         endcase
      end
   end

   // Parser consumes the byte on the stop-sample edge itself to save a cycle of latency.
   assign stop_tick = (ustate == U_STOP) && (baud_cnt == BIT_LAST);
   assign byte_vld  = stop_tick && rxd_s2;
   assign byte_ferr = stop_tick && !rxd_s2;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pstate      <= P_HUNT;
         match       <= 1'b0;
         cmd_refresh <= 1'b0;
         col_cnt     <= '0;
         oCOL_WE     <= 1'b0;
         oCOL_ADDR   <= '0;
         oCOL_DATA   <= '0;
         oFRAME_DONE <= 1'b0;
         oREFRESH    <= 1'b0;
         oFRAME_ERR  <= 1'b0;
      end else begin
         oCOL_WE     <= 1'b0;
         oFRAME_DONE <= 1'b0;
         oREFRESH    <= 1'b0;
         oFRAME_ERR  <= 1'b0;
         if (byte_ferr) begin
            oFRAME_ERR <= 1'b1;
            pstate     <= P_HUNT;
         end else if (byte_vld) begin
            case (pstate)
               P_HUNT: begin
                  if (shift_dat == 8'h80) pstate <= P_CMD;
               end
               P_CMD: begin
                  if (shift_dat == 8'h83 || shift_dat == 8'h84) begin
                     cmd_refresh <= (shift_dat == 8'h83);
                     pstate      <= P_ADDR;
                  end else if (shift_dat != 8'h80) begin
                     oFRAME_ERR <= 1'b1;
                     pstate     <= P_HUNT;
                  end
               end
               P_ADDR: begin
                  match   <= (shift_dat == PANEL_ADDR) || (shift_dat == 8'hFF);
                  col_cnt <= '0;
                  pstate  <= P_DATA;
               end
               P_DATA: begin
                  if (!shift_dat[7]) begin
                     if (match) begin
                        oCOL_WE   <= 1'b1;
                        oCOL_ADDR <= col_cnt;
                        oCOL_DATA <= shift_dat[6:0];
                     end
                     col_cnt <= col_cnt + 5'd1;
                     if (col_cnt == 5'd27) pstate <= P_END;
                  end else begin
                     oFRAME_ERR <= 1'b1;
                     pstate     <= (shift_dat == 8'h80) ? P_CMD : P_HUNT;
                  end
               end
               P_END: begin
                  if (shift_dat == 8'h8F) begin
                     if (match) begin
                        oFRAME_DONE <= 1'b1;
                        oREFRESH    <= cmd_refresh;
                     end
                  end else begin
                     oFRAME_ERR <= 1'b1;
                  end
                  pstate <= P_HUNT;
               end
               default: pstate <= P_HUNT;
            endcase
         end
      end
   end

   assign oBUSY = (pstate != P_HUNT);

endmodule
